// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF side of the IF/ID register.
//   Holds the PC, translates it through the instruction MMU port, performs a
//   single outstanding req/ack read on the instruction bus and presents the
//   fetched slot (pc, instruction, TLB status) to IF/ID. Handles exception
//   flush, taken branches (with the MIPS delay slot) and discarding of bus
//   responses that belong to a flushed fetch.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   stall[5:0]      pipeline stall vector; stall[1] holds IF
//   flush/flush_pc  exception redirect (highest priority)
//   branch_taken/branch_target  redirect resolved in ID
//   mmu_vaddr       PC presented to the instruction MMU
//   mmu_paddr/mmu_miss/mmu_valid  same-cycle translation result
//   ibus_req/ibus_addr/ibus_ack/ibus_rdata  instruction bus
//   if_pc/if_inst_addr_v/if_inst/if_miss/if_valid  slot presented to IF/ID
//   stallreq_if     IF not ready this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] mmu_vaddr,
  input  logic [ADDR_W-1:0] mmu_paddr,
  input  logic              mmu_miss,
  input  logic              mmu_valid,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_ack,
  input  logic [31:0]       ibus_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_inst_addr_v,
  output logic [31:0]       if_inst,
  output logic              if_miss,
  output logic              if_valid,
  output logic              stallreq_if
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       inst_buf_q;
  logic              redirect_pending_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              miss_q;
  logic              valid_q;

  logic              ack_in_wait;
  logic              advance;
  logic              tlb_fault;
  logic [ADDR_W-1:0] next_pc_d;

  // Only stall[1] concerns this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  always_comb begin
    ack_in_wait = (state_q == S_WAIT) && ibus_ack;
    advance     = ((state_q == S_HOLD) || ack_in_wait) && !stall[1];
    tlb_fault   = mmu_miss || !mmu_valid;

    if (flush)                   next_pc_d = flush_pc;
    else if (branch_taken)       next_pc_d = branch_target;
    else if (redirect_pending_q) next_pc_d = redirect_pc_q;
    else                         next_pc_d = pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_FETCH;
      pc_q               <= RESET_PC;
      addr_q             <= '0;
      inst_buf_q         <= '0;
      redirect_pending_q <= 1'b0;
      redirect_pc_q      <= '0;
      miss_q             <= 1'b0;
      valid_q            <= 1'b1;
    end else if (flush) begin
      pc_q               <= flush_pc;
      redirect_pending_q <= 1'b0;
      // A request still in flight must have its response swallowed.
      if (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !ibus_ack)
        state_q <= S_DISCARD;
      else
        state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (tlb_fault) begin
            miss_q     <= mmu_miss;
            valid_q    <= mmu_valid;
            inst_buf_q <= '0;
            state_q    <= S_HOLD;
          end else begin
            addr_q  <= mmu_paddr;
            miss_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ibus_ack) begin
            inst_buf_q <= ibus_rdata;
            miss_q     <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          state_q <= S_HOLD;
        end
        S_DISCARD: begin
          if (ibus_ack) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase

      // Advance overrides the per-state next state above.
      if (advance) begin
        pc_q               <= next_pc_d;
        state_q            <= S_FETCH;
        redirect_pending_q <= 1'b0;
      end else if (branch_taken) begin
        // Slot in IF is the delay slot; remember the target for the next fetch.
        redirect_pending_q <= 1'b1;
        redirect_pc_q      <= branch_target;
      end
    end
  end

  always_comb begin
    mmu_vaddr      = pc_q;
    if_pc          = pc_q;
    if_inst_addr_v = pc_q;

    ibus_req  = !rst && (((state_q == S_FETCH) && !tlb_fault) || (state_q == S_WAIT));
    ibus_addr = (state_q == S_WAIT) ? addr_q : mmu_paddr;

    if (ack_in_wait) begin
      if_inst  = ibus_rdata;
      if_miss  = 1'b0;
      if_valid = 1'b1;
    end else begin
      if_inst  = (state_q == S_HOLD) ? inst_buf_q : '0;
      if_miss  = miss_q;
      if_valid = valid_q;
    end

    stallreq_if = rst || !((state_q == S_HOLD) || ack_in_wait);
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mmu_vaddr;
  logic [31:0] mmu_paddr;
  logic        mmu_miss;
  logic        mmu_valid;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst_addr_v;
  logic [31:0] if_inst;
  logic        if_miss;
  logic        if_valid;
  logic        stallreq_if;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        miss;
    logic        valid;
  } slot_t;
  slot_t sb[$];

  always #5 clk = ~clk;

  // Unmapped-segment style translation: strip the top three bits.
  assign mmu_paddr = mmu_vaddr & 32'h1FFF_FFFF;

  if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mmu_vaddr(mmu_vaddr), .mmu_paddr(mmu_paddr), .mmu_miss(mmu_miss),
    .mmu_valid(mmu_valid), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .if_pc(if_pc),
    .if_inst_addr_v(if_inst_addr_v), .if_inst(if_inst), .if_miss(if_miss),
    .if_valid(if_valid), .stallreq_if(stallreq_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // IF/ID loads a slot whenever IF is ready and not held.
  always @(negedge clk) begin
    if (!rst && !stallreq_if && !stall[1]) begin
      slot_t e;
      if (sb.size() == 0) begin
        chk("unexpected_delivery_pc", if_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("deliv_pc", if_pc, e.pc);
        chk("deliv_vaddr", if_inst_addr_v, e.pc);
        chk("deliv_inst", if_inst, e.inst);
        chk("deliv_miss", {31'd0, if_miss}, {31'd0, e.miss});
        chk("deliv_valid", {31'd0, if_valid}, {31'd0, e.valid});
      end
    end
  end

  // Wait (bounded) for a request, check it, hold for d WAIT cycles, then ack.
  // Returns at posedge+1 of the cycle after the ack.
  task automatic fetch(input logic [31:0] exp_pc, input int unsigned d,
                       input logic [31:0] data, input logic br, input logic [31:0] tgt);
    bit seen = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ibus_req) begin seen = 1; break; end
    end
    chk("req_seen", {31'd0, seen}, 32'd1);
    chk("req_pc", if_pc, exp_pc);
    chk("req_addr", ibus_addr, exp_pc & 32'h1FFF_FFFF);
    chk("stallreq_fetch", {31'd0, stallreq_if}, 32'd1);
    for (int unsigned j = 0; j < d; j++) begin
      tick();
      @(negedge clk);
      chk("wait_req", {31'd0, ibus_req}, 32'd1);
      chk("wait_addr", ibus_addr, exp_pc & 32'h1FFF_FFFF);
      chk("wait_stallreq", {31'd0, stallreq_if}, 32'd1);
    end
    tick();
    ibus_ack = 1'b1; ibus_rdata = data;
    branch_taken = br; branch_target = tgt;
    sb.push_back('{pc: exp_pc, inst: data, miss: 1'b0, valid: 1'b1});
    @(negedge clk);
    chk("ack_inst", if_inst, data);
    chk("ack_stallreq", {31'd0, stallreq_if}, 32'd0);
    tick();
    ibus_ack = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; flush_pc = '0;
    branch_taken = 1'b0; branch_target = '0; mmu_miss = 1'b0; mmu_valid = 1'b1;
    ibus_ack = 1'b0; ibus_rdata = '0;

    // 1. reset and back-to-back fetches
    tick();
    ibus_ack = 1'b1; ibus_rdata = 32'h1234_5678;  // ignored during reset
    tick();
    ibus_ack = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, ibus_req}, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq_if}, 32'd1);
    chk("rst_pc", if_pc, 32'hBFC0_0000);
    chk("rst_inst", if_inst, 32'd0);
    tick();
    rst = 1'b0;
    fetch(32'hBFC0_0000, 0, 32'h2400_0001, 1'b0, '0);
    fetch(32'hBFC0_0004, 0, 32'h2400_0002, 1'b0, '0);

    // 3. branch while delay slot is in WAIT; second branch under stall
    begin
      bit seen = 0;
      for (int unsigned i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ibus_req) begin seen = 1; break; end
      end
      chk("ds_req_seen", {31'd0, seen}, 32'd1);
      chk("ds_addr", ibus_addr, 32'h1FC0_0008);
    end
    tick();
    branch_taken = 1'b1; branch_target = 32'h8000_0100;
    @(negedge clk);
    chk("ds_wait_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    stall = 6'b000010; ibus_ack = 1'b1; ibus_rdata = 32'h2400_0003;
    branch_taken = 1'b1; branch_target = 32'h8000_0100;
    sb.push_back('{pc: 32'hBFC0_0008, inst: 32'h2400_0003, miss: 1'b0, valid: 1'b1});
    @(negedge clk);
    chk("ds_ack_stallreq", {31'd0, stallreq_if}, 32'd0);
    tick();
    stall = '0; ibus_ack = 1'b0; branch_taken = 1'b0;
    tick();
    fetch(32'h8000_0100, 0, 32'h2400_0010, 1'b0, '0);

    // 2. delayed ack
    fetch(32'h8000_0104, 5, 32'h2400_0011, 1'b0, '0);

    // 4. flush during WAIT, stale ack discarded
    begin
      bit seen = 0;
      for (int unsigned i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ibus_req) begin seen = 1; break; end
      end
      chk("fl_req_seen", {31'd0, seen}, 32'd1);
      chk("fl_addr", ibus_addr, 32'h0000_0108);
    end
    tick();
    flush = 1'b1; flush_pc = 32'h8000_0180;
    @(negedge clk);
    chk("fl_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("disc_req", {31'd0, ibus_req}, 32'd0);
    chk("disc_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    ibus_ack = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("disc_ack_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    ibus_ack = 1'b0;
    fetch(32'h8000_0180, 0, 32'h2400_0020, 1'b1, 32'h0040_0000);

    // 5. TLB refill miss, then invalid entry
    mmu_miss = 1'b1;
    sb.push_back('{pc: 32'h0040_0000, inst: 32'd0, miss: 1'b1, valid: 1'b1});
    @(negedge clk);
    chk("miss_req", {31'd0, ibus_req}, 32'd0);
    chk("miss_pc", if_pc, 32'h0040_0000);
    tick();
    mmu_miss = 1'b0; mmu_valid = 1'b0;
    sb.push_back('{pc: 32'h0040_0004, inst: 32'd0, miss: 1'b0, valid: 1'b0});
    tick();
    @(negedge clk);
    chk("inv_req", {31'd0, ibus_req}, 32'd0);
    tick();
    mmu_valid = 1'b1;
    tick();

    // 6. stall hold in HOLD
    begin
      bit seen = 0;
      for (int unsigned i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ibus_req) begin seen = 1; break; end
      end
      chk("st_req_seen", {31'd0, seen}, 32'd1);
      chk("st_addr", ibus_addr, 32'h0040_0008);
    end
    tick();
    stall = 6'b000010; ibus_ack = 1'b1; ibus_rdata = 32'h2400_0030;
    sb.push_back('{pc: 32'h0040_0008, inst: 32'h2400_0030, miss: 1'b0, valid: 1'b1});
    tick();
    ibus_ack = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_pc", if_pc, 32'h0040_0008);
      chk("hold_inst", if_inst, 32'h2400_0030);
      chk("hold_stallreq", {31'd0, stallreq_if}, 32'd0);
      tick();
    end
    stall = '0;
    tick();

    // 6. reset mid-WAIT
    begin
      bit seen = 0;
      for (int unsigned i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ibus_req) begin seen = 1; break; end
      end
      chk("rw_req_seen", {31'd0, seen}, 32'd1);
      chk("rw_addr", ibus_addr, 32'h0040_000C);
    end
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rst_req", {31'd0, ibus_req}, 32'd0);
    chk("rw_rst_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    ibus_ack = 1'b1; ibus_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 1'b0; ibus_ack = 1'b0;
    fetch(32'hBFC0_0000, 0, 32'h2400_0001, 1'b0, '0);

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
